// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   - FSM state encodings (RUN, LDSTALL, FLUSH, MWAIT)
//   - NOP instruction loaded into IF/ID on a flush
//   - instruction field slice positions for rs/rt
//   - packed bundle of the pipeline control outputs
package pipe_pkg;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_LDSTALL = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;
   localparam logic [1:0] ST_MWAIT   = 2'd3;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int REG_W  = RS_MSB - RS_LSB + 1;

   typedef logic [REG_W-1:0] reg_idx_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_flush;
      logic pipe_hold;
   } pipe_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
//   slave  : controller side (decode/stage fields in, enables/flushes out)
//   master : datapath side (drives stage fields, consumes enables/flushes)
interface pipe_hazard_ctl_if;
   import pipe_pkg::*;

   reg_idx_t if_id_rs;
   reg_idx_t if_id_rt;
   logic     if_id_uses_rt;
   logic     id_ex_memread;
   reg_idx_t id_ex_rt;
   logic     ex_mem_branch_taken;
   logic     ex_mem_memaccess;
   logic     dmem_ready;

   logic     pc_write;
   logic     if_id_write;
   logic     if_id_flush;
   logic     id_ex_bubble;
   logic     ex_mem_flush;
   logic     pipe_hold;

   modport slave (
      input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_memread, id_ex_rt,
             ex_mem_branch_taken, ex_mem_memaccess, dmem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
             pipe_hold
   );

   modport master (
      output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_memread, id_ex_rt,
             ex_mem_branch_taken, ex_mem_memaccess, dmem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
             pipe_hold
   );

endinterface

// File: rtl/pipe_hazard_ctl_hazard_detect.sv
// Combinational load-use hazard detector, shared with the forwarding unit.
//   id_ex_memread, id_ex_rt : load in EX and its destination register
//   if_id_rs, if_id_rt      : decode-stage source fields
//   if_id_uses_rt           : decode instruction actually reads rt
//   hazard                  : decode must wait one cycle for the load
module hazard_detect
   import pipe_pkg::*;
(
   input  logic     id_ex_memread,
   input  reg_idx_t id_ex_rt,
   input  reg_idx_t if_id_rs,
   input  reg_idx_t if_id_rt,
   input  logic     if_id_uses_rt,
   output logic     hazard
);

   // $zero is never a real dependency
   assign hazard = id_ex_memread & (id_ex_rt != '0) &
                   ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard and stall controller for the 5-stage pipeline.
//   clk, rst_n   : pipeline clock, async active-low reset
//   pif (slave)  : stage fields in; PC/IF-ID enables, flushes, bubble, hold out
//   state        : current FSM state
//   stall_cnt    : load-use bubbles inserted (saturating)
//   flush_cnt    : branch flushes (saturating)
//   err_timeout  : sticky, memory wait reached MEM_TIMEOUT cycles
//
// state   | meaning
// RUN     | normal flow
// LDSTALL | bubble inserted last cycle; hazard masked this cycle
// FLUSH   | younger stages squashed last cycle (behaves as RUN)
// MWAIT   | pipeline frozen waiting for data memory
module pipe_hazard_ctl
   import pipe_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_hazard_ctl_if.slave pif,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             err_timeout
);

   localparam logic [CNT_W-1:0] CNT_ONE     = 1;
   localparam logic [7:0]       TIMEOUT_VAL = 8'(MEM_TIMEOUT);

   logic       hazard;
   logic       mwait;
   logic       take_branch;
   logic       do_bubble;
   logic [1:0] next_state;
   logic [7:0] wait_cnt;
   logic [7:0] wait_inc;
   pipe_ctl_t  ctl;

   hazard_detect u_hazard_detect (
      .id_ex_memread (pif.id_ex_memread),
      .id_ex_rt      (pif.id_ex_rt),
      .if_id_rs      (pif.if_id_rs),
      .if_id_rt      (pif.if_id_rt),
      .if_id_uses_rt (pif.if_id_uses_rt),
      .hazard        (hazard)
   );

   // strict priority: memory hold > branch flush > load-use bubble > run
   assign mwait       = pif.ex_mem_memaccess & ~pif.dmem_ready;
   assign take_branch = ~mwait & pif.ex_mem_branch_taken;
   assign do_bubble   = ~mwait & ~pif.ex_mem_branch_taken & hazard &
                        (state != ST_LDSTALL);

   always_comb begin
      ctl        = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
      next_state = ST_RUN;
      if (mwait) begin
         ctl        = '{pipe_hold: 1'b1, default: 1'b0};
         next_state = ST_MWAIT;
      end else if (take_branch) begin
         ctl        = '{pipe_hold: 1'b0, default: 1'b1};
         next_state = ST_FLUSH;
      end else if (do_bubble) begin
         ctl        = '{id_ex_bubble: 1'b1, default: 1'b0};
         next_state = ST_LDSTALL;
      end
      // keep the whole pipeline frozen for as long as reset is held
      if (!rst_n) begin
         ctl = '{pipe_hold: 1'b1, default: 1'b0};
      end
   end

   assign pif.pc_write     = ctl.pc_write;
   assign pif.if_id_write  = ctl.if_id_write;
   assign pif.if_id_flush  = ctl.if_id_flush;
   assign pif.id_ex_bubble = ctl.id_ex_bubble;
   assign pif.ex_mem_flush = ctl.ex_mem_flush;
   assign pif.pipe_hold    = ctl.pipe_hold;

   assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         state <= next_state;
         if (mwait) begin
            wait_cnt <= wait_inc;
            if (wait_inc == TIMEOUT_VAL) begin
               err_timeout <= 1'b1;
            end
         end else begin
            wait_cnt <= '0;
         end
         if (take_branch && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
         if (do_bubble && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
module tb_pipe_hazard_ctl;

   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam int TMO    = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             err_timeout;

   pipe_hazard_ctl_if pif ();

   pipe_hazard_ctl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pif         (pif.slave),
      .state       (state),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold}
   logic [5:0] ctl_obs;
   assign ctl_obs = {pif.pc_write, pif.if_id_write, pif.if_id_flush,
                     pif.id_ex_bubble, pif.ex_mem_flush, pif.pipe_hold};

   int total = 0;
   int bad   = 0;

   // reference model: status code, counters and wait run length
   int m_state, m_stall, m_flush, m_wait;
   bit m_err;

   function automatic bit model_hazard();
      return pif.id_ex_memread && (pif.id_ex_rt != 0) &&
             ((pif.id_ex_rt == pif.if_id_rs) ||
              (pif.if_id_uses_rt && (pif.id_ex_rt == pif.if_id_rt)));
   endfunction

   // 0 run, 1 bubble, 2 flush, 3 memory hold
   function automatic int model_outcome();
      if (pif.ex_mem_memaccess && !pif.dmem_ready) return 3;
      if (pif.ex_mem_branch_taken)                  return 2;
      if (model_hazard() && m_state != 1)           return 1;
      return 0;
   endfunction

   function automatic logic [5:0] model_ctl(int oc);
      case (oc)
         1:       return 6'b000100;
         2:       return 6'b111110;
         3:       return 6'b000001;
         default: return 6'b110000;
      endcase
   endfunction

   function automatic logic [10:0] model_regs();
      return {2'(m_state), 4'(m_stall), 4'(m_flush), m_err};
   endfunction

   task automatic model_reset();
      m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_err = 0;
   endtask

   // advance one clock; model sees the inputs that were stable before the edge
   task automatic tick();
      int oc;
      oc = model_outcome();
      @(posedge clk);
      #1;
      m_state = oc == 1 ? 1 : oc == 2 ? 2 : oc == 3 ? 3 : 0;
      if (oc == 3) begin
         m_wait = (m_wait < 255) ? m_wait + 1 : 255;
         if (m_wait >= TMO) m_err = 1;
      end else begin
         m_wait = 0;
      end
      if (oc == 2) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (oc == 1) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
   endtask

   task automatic set_idle();
      pif.if_id_rs = 5'd0; pif.if_id_rt = 5'd0; pif.if_id_uses_rt = 1'b0;
      pif.id_ex_memread = 1'b0; pif.id_ex_rt = 5'd0;
      pif.ex_mem_branch_taken = 1'b0; pif.ex_mem_memaccess = 1'b0;
      pif.dmem_ready = 1'b1;
   endtask

   task automatic do_reset(int n);
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      set_idle();
      pif.id_ex_memread = 1'b1; pif.id_ex_rt = 5'd4; pif.if_id_rs = 5'd4;
      pif.ex_mem_branch_taken = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (ctl_obs !== 6'b000001) begin
         bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl_obs, 6'b000001);
      end
      total++;
      if ({state, stall_cnt, flush_cnt, err_timeout} !== 11'd0) begin
         bad++; $display("FAIL reset_regs state=%0d stall=%0d flush=%0d err=%0d exp all 0",
                         state, stall_cnt, flush_cnt, err_timeout);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      set_idle();
   endtask

   task automatic test_load_use();
      do_reset(2);
      set_idle();
      pif.id_ex_memread = 1'b1; pif.id_ex_rt = 5'd2;
      pif.if_id_rs = 5'd2; pif.if_id_rt = 5'd7; pif.if_id_uses_rt = 1'b1;
      #2;
      total++;
      if (ctl_obs !== 6'b000100) begin
         bad++; $display("FAIL load_use_bubble got=%b exp=%b", ctl_obs, 6'b000100);
      end
      tick();
      #2;
      total++;
      if (state !== 2'd1 || ctl_obs !== 6'b110000) begin
         bad++; $display("FAIL load_use_masked state=%0d ctl=%b exp state=1 ctl=110000", state, ctl_obs);
      end
      tick();
      set_idle();
      total++;
      if (state !== 2'd0 || stall_cnt !== 4'd1) begin
         bad++; $display("FAIL load_use_done state=%0d stall=%0d exp 0/1", state, stall_cnt);
      end
   endtask

   task automatic test_branch_hazard();
      do_reset(1);
      set_idle();
      pif.id_ex_memread = 1'b1; pif.id_ex_rt = 5'd9; pif.if_id_rs = 5'd9;
      pif.ex_mem_branch_taken = 1'b1;
      #2;
      total++;
      if (ctl_obs !== 6'b111110) begin
         bad++; $display("FAIL branch_hazard_ctl got=%b exp=%b", ctl_obs, 6'b111110);
      end
      tick();
      set_idle();
      total++;
      if (state !== 2'd2 || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
         bad++; $display("FAIL branch_hazard_regs state=%0d flush=%0d stall=%0d exp 2/1/0",
                         state, flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_rt_zero();
      set_idle();
      pif.id_ex_memread = 1'b1; pif.id_ex_rt = 5'd0;
      pif.if_id_rs = 5'd0; pif.if_id_rt = 5'd0; pif.if_id_uses_rt = 1'b1;
      #2;
      total++;
      if (ctl_obs !== 6'b110000) begin
         bad++; $display("FAIL rt_zero_ctl got=%b exp=%b", ctl_obs, 6'b110000);
      end
      tick();
      set_idle();
      total++;
      if (state !== 2'd0) begin
         bad++; $display("FAIL rt_zero_state got=%0d exp=0", state);
      end
   endtask

   task automatic test_mem_timeout();
      int errs;
      errs = 0;
      do_reset(1);
      set_idle();
      pif.ex_mem_memaccess = 1'b1; pif.dmem_ready = 1'b0;
      pif.ex_mem_branch_taken = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         #2;
         if (ctl_obs !== 6'b000001) begin
            errs++; $display("FAIL mwait_hold cyc=%0d got=%b exp=000001", k, ctl_obs);
         end
         tick();
         if (state !== 2'd3 || err_timeout !== (k >= TMO) || flush_cnt !== 4'd0) begin
            errs++; $display("FAIL mwait_regs cyc=%0d state=%0d err=%0d flush=%0d exp 3/%0d/0",
                             k, state, err_timeout, flush_cnt, (k >= TMO));
         end
      end
      total++;
      if (errs != 0) bad++;
      pif.dmem_ready = 1'b1;
      #2;
      total++;
      if (ctl_obs !== 6'b111110) begin
         bad++; $display("FAIL mwait_exit_branch got=%b exp=111110", ctl_obs);
      end
      tick();
      set_idle();
      repeat (3) tick();
      total++;
      if (flush_cnt !== 4'd1 || err_timeout !== 1'b1 || state !== 2'd0) begin
         bad++; $display("FAIL mwait_after flush=%0d err=%0d state=%0d exp 1/1/0",
                         flush_cnt, err_timeout, state);
      end
      do_reset(1);
      total++;
      if (err_timeout !== 1'b0) begin
         bad++; $display("FAIL timeout_clear got=%0d exp=0", err_timeout);
      end
   endtask

   task automatic test_short_wait();
      do_reset(1);
      set_idle();
      pif.ex_mem_memaccess = 1'b1;
      // two runs of 14 separated by a ready cycle must not trip the flag
      for (int r = 0; r < 2; r++) begin
         pif.dmem_ready = 1'b0;
         repeat (TMO - 1) tick();
         pif.dmem_ready = 1'b1;
         tick();
      end
      total++;
      if (err_timeout !== 1'b0) begin
         bad++; $display("FAIL wait_run_clear got=%0d exp=0", err_timeout);
      end
      set_idle();
   endtask

   task automatic test_reset_abort();
      do_reset(1);
      set_idle();
      pif.id_ex_memread = 1'b1; pif.id_ex_rt = 5'd3; pif.if_id_rt = 5'd3;
      pif.if_id_uses_rt = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (state !== 2'd0 || stall_cnt !== 4'd0 || ctl_obs !== 6'b000001) begin
         bad++; $display("FAIL reset_abort state=%0d stall=%0d ctl=%b exp 0/0/000001",
                         state, stall_cnt, ctl_obs);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      set_idle();
   endtask

   task automatic test_saturation();
      do_reset(1);
      for (int i = 1; i <= 17; i++) begin
         set_idle();
         pif.id_ex_memread = 1'b1; pif.id_ex_rt = 5'd6; pif.if_id_rs = 5'd6;
         tick();
         set_idle();
         tick();
      end
      total++;
      if (stall_cnt !== 4'd15) begin
         bad++; $display("FAIL stall_saturate got=%0d exp=15", stall_cnt);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      do_reset(1);
      for (int i = 0; i < 600; i++) begin
         pif.if_id_rs            = 5'($urandom_range(0, 3));
         pif.if_id_rt            = 5'($urandom_range(0, 3));
         pif.if_id_uses_rt       = 1'($urandom_range(0, 1));
         pif.id_ex_memread       = ($urandom_range(0, 2) != 0);
         pif.id_ex_rt            = 5'($urandom_range(0, 3));
         pif.ex_mem_branch_taken = ($urandom_range(0, 5) == 0);
         pif.ex_mem_memaccess    = ($urandom_range(0, 3) == 0);
         pif.dmem_ready          = ($urandom_range(0, 3) != 0);
         #2;
         if (ctl_obs !== model_ctl(model_outcome())) begin
            errs++; $display("FAIL rand_ctl i=%0d got=%b exp=%b", i, ctl_obs, model_ctl(model_outcome()));
         end
         tick();
         if ({state, stall_cnt, flush_cnt, err_timeout} !== model_regs()) begin
            errs++; $display("FAIL rand_regs i=%0d got=%b exp=%b", i,
                             {state, stall_cnt, flush_cnt, err_timeout}, model_regs());
         end
      end
      total++;
      if (errs != 0) bad++;
      set_idle();
   endtask

   initial begin
      set_idle();
      model_reset();
      test_reset();
      test_load_use();
      test_branch_hazard();
      test_rt_zero();
      test_mem_timeout();
      test_short_wait();
      test_reset_abort();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Hazard and stall controller for the 5-stage MIPS pipeline. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and sequences them. It detects load-use hazards against the decode stage and inserts one bubble into ID/EX. It squashes the three younger stages on a taken branch resolved in MEM, and freezes the whole pipeline while data memory is not ready. It also keeps saturating stall/flush event counters and a sticky memory-timeout flag for the bench and debug.

## Interface
- CNT_W, 16, width of stall_cnt and flush_cnt
- MEM_TIMEOUT, 15, consecutive MWAIT cycles before err_timeout is set (1..255)

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_id_rs  in  5  IF/ID instruction [25:21]
- if_id_rt  in  5  IF/ID instruction [20:16]
- if_id_uses_rt  in  1  decode instruction reads rt as a source (R-type, beq, sw)
- id_ex_memread  in  1  ID/EX M-control memread bit
- id_ex_rt  in  5  ID/EX instrout_2016 (load destination)
- ex_mem_branch_taken  in  1  EX/MEM branch AND zero
- ex_mem_memaccess  in  1  EX/MEM memread OR memwrite
- dmem_ready  in  1  data memory can complete this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP (0x00000000)
- id_ex_bubble  out  1  ID/EX loads all-zero WB/M/EX controls
- ex_mem_flush  out  1  EX/MEM loads all-zero WB/M controls
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents
- state  out  2  RUN=0, LDSTALL=1, FLUSH=2, MWAIT=3
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  branch flushes, saturating
- err_timeout  out  1  sticky; set when the MWAIT run length reaches MEM_TIMEOUT

## Operation
- hazard = id_ex_memread & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & id_ex_rt == if_id_rt)).
- Control outputs are combinational from the current state and inputs. state, counters and err_timeout are registered. Evaluation uses strict priority each cycle:
  1. mwait = ex_mem_memaccess & !dmem_ready. pipe_hold=1, pc_write=0, if_id_write=0, no flush or bubble. Next state MWAIT. wait_cnt increments, saturating at 255. When it reaches MEM_TIMEOUT, err_timeout is set and stays set until reset.
  2. ex_mem_branch_taken. pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1. Next state FLUSH. flush_cnt increments.
  3. hazard & state != LDSTALL. pc_write=0, if_id_write=0, id_ex_bubble=1. Next state LDSTALL. stall_cnt increments.
  4. Otherwise: pc_write=1, if_id_write=1, all flush, bubble and hold signals 0. Next state RUN.
- wait_cnt (internal, 8 bit) clears on any cycle that is not mwait.
- LDSTALL masks hazard for exactly one cycle. At most one bubble is inserted per load.
- FLUSH and RUN behave identically. FLUSH is status only.
- Exit from MWAIT happens when dmem_ready=1. Priorities 2–4 are evaluated in that same cycle.
- Counters saturate at all-ones and never wrap.

## Timing
- Zero-cycle latency from inputs to the control outputs. Registered state is visible the cycle after the causing edge.
- While rst_n=0 (asynchronous):
  - Registers: state=RUN, stall_cnt=0, flush_cnt=0, wait_cnt=0, err_timeout=0.
  - Outputs forced: pc_write=0, if_id_write=0, pipe_hold=1, if_id_flush=0, id_ex_bubble=0, ex_mem_flush=0.
- The first rising edge after deassertion evaluates normally.
- Reset asserted mid-stall or mid-MWAIT aborts immediately. No pending bubble or flush survives reset.
- Simultaneous branch and hazard: the flush wins and stall_cnt does not increment.
- Simultaneous mwait and branch: the hold wins. The branch is re-evaluated when ready, and flush_cnt increments once.
- Hazard with id_ex_rt=0 never stalls.

## Structure
- Shared package pipe_pkg holds:
  - state encodings RUN/LDSTALL/FLUSH/MWAIT
  - NOP instruction constant
  - field slice constants RS_MSB/RS_LSB/RT_MSB/RT_LSB
- One sub-module, hazard_detect, holds the combinational hazard equation so the forwarding unit can reuse it.
- The FSM, counters and timeout logic live in the top module.

## Test plan
- Reset with rst_n=0 for 3 cycles: pc_write=0, pipe_hold=1, stall_cnt=0, flush_cnt=0, state=0.
- lw $2 in ID/EX (memread=1, id_ex_rt=2) with add using rs=2 in IF/ID: one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then state=1, then RUN; stall_cnt=1.
- ex_mem_branch_taken=1 in the same cycle as a hazard: all three flush signals=1, pc_write=1, state=2, flush_cnt=1, stall_cnt=0.
- Hazard with id_ex_rt=0 and rs=0: no stall, state stays RUN.
- ex_mem_memaccess=1, dmem_ready=0 for 20 cycles with MEM_TIMEOUT=15: pipe_hold=1 throughout, state=3, err_timeout=1 from the 15th cycle; the flag stays 1 after ready returns and clears only on reset.
- Force stall_cnt near all-ones (CNT_W=4, 17 load-use events): stall_cnt saturates at 15.
